// File: rtl/uart_frame_ram_writer.sv
// UART frame to delay-RAM writer.
// Turns the received byte stream into addressed RAM writes. A frame is
// HDR, GA, CH, address bytes, data bytes, CHK. Writes go to one of N_CH
// channels, or to all of them when CH is 8'hFF. Checksum errors, illegal
// channels and inter-byte timeouts are reported as one-cycle pulses.
module uart_frame_ram_writer #(
  parameter int          N_CH        = 4,
  parameter int          ADDR_W      = 11,
  parameter int          DATA_W      = 24,
  parameter int          GA_W        = 5,
  parameter logic [7:0]  HDR         = 8'hAA,
  parameter int          TIMEOUT_CYC = 20000
) (
  input  logic                     I_clk_10M,
  input  logic                     I_rst,
  input  logic [7:0]               I_rx_data,
  input  logic                     I_rx_vld,
  input  logic [GA_W-1:0]          I_GA,
  output logic [N_CH-1:0]          O_WEA,
  output logic [N_CH*ADDR_W-1:0]   O_WRITE_ADDR,
  output logic [N_CH*DATA_W-1:0]   O_WRITE_DATA,
  output logic                     O_ERR_CHK,
  output logic                     O_ERR_CH,
  output logic                     O_ERR_TO,
  output logic [15:0]              O_FRAME_CNT
);

  localparam int AB   = (ADDR_W + 7) / 8;
  localparam int DB   = (DATA_W + 7) / 8;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0]      AB_LAST  = 3'(AB - 1);
  localparam logic [2:0]      DB_LAST  = 3'(DB - 1);
  localparam logic [7:0]      N_CH_B   = 8'(N_CH);
  localparam logic [7:0]      CH_BCAST = 8'hFF;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GA,
    S_CH,
    S_ADDR,
    S_DATA,
    S_CHK
  } state_t;

  state_t              state;
  logic                ga_hit;
  logic [7:0]          ch_r;
  logic [ADDR_W-1:0]   addr_sr;
  logic [DATA_W-1:0]   data_sr;
  logic [7:0]          xor_acc;
  logic [2:0]          bcnt;
  logic [TO_W-1:0]     to_cnt;
  logic                ga_match;

  // Shift a byte in at the bottom, keeping only the low ADDR_W bits so
  // surplus high bits of the first address byte fall off the top.
  function automatic logic [ADDR_W-1:0] shift_addr(input logic [ADDR_W-1:0] sr,
                                                   input logic [7:0] b);
    logic [ADDR_W+7:0] t;
    t = {sr, b};
    return t[ADDR_W-1:0];
  endfunction

  // Same as shift_addr, for the data word.
  function automatic logic [DATA_W-1:0] shift_data(input logic [DATA_W-1:0] sr,
                                                   input logic [7:0] b);
    logic [DATA_W+7:0] t;
    t = {sr, b};
    return t[DATA_W-1:0];
  endfunction

  // GA byte addresses this board when its low bits match, or are all ones.
  assign ga_match = (I_rx_data[GA_W-1:0] == I_GA) || (&I_rx_data[GA_W-1:0]);

  // Frame parser, timeout supervision and registered write/error outputs.
  always_ff @(posedge I_clk_10M) begin
    if (I_rst) begin
      state        <= S_IDLE;
      ga_hit       <= 1'b0;
      ch_r         <= '0;
      addr_sr      <= '0;
      data_sr      <= '0;
      xor_acc      <= '0;
      bcnt         <= '0;
      to_cnt       <= '0;
      O_WEA        <= '0;
      O_WRITE_ADDR <= '0;
      O_WRITE_DATA <= '0;
      O_ERR_CHK    <= 1'b0;
      O_ERR_CH     <= 1'b0;
      O_ERR_TO     <= 1'b0;
      O_FRAME_CNT  <= '0;
    end else begin
      O_WEA     <= '0;
      O_ERR_CHK <= 1'b0;
      O_ERR_CH  <= 1'b0;
      O_ERR_TO  <= 1'b0;

      if (I_rx_vld) begin
        // Any received byte restarts the idle timer, including one that
        // lands in the cycle the timer would otherwise expire.
        to_cnt <= '0;
        case (state)
          S_IDLE: begin
            xor_acc <= '0;
            if (I_rx_data == HDR) state <= S_GA;
          end
          S_GA: begin
            ga_hit  <= ga_match;
            xor_acc <= xor_acc ^ I_rx_data;
            state   <= S_CH;
          end
          S_CH: begin
            ch_r    <= I_rx_data;
            xor_acc <= xor_acc ^ I_rx_data;
            bcnt    <= '0;
            state   <= S_ADDR;
          end
          S_ADDR: begin
            addr_sr <= shift_addr(addr_sr, I_rx_data);
            xor_acc <= xor_acc ^ I_rx_data;
            if (bcnt == AB_LAST) begin
              bcnt  <= '0;
              state <= S_DATA;
            end else begin
              bcnt <= bcnt + 3'd1;
            end
          end
          S_DATA: begin
            data_sr <= shift_data(data_sr, I_rx_data);
            xor_acc <= xor_acc ^ I_rx_data;
            if (bcnt == DB_LAST) begin
              bcnt  <= '0;
              state <= S_CHK;
            end else begin
              bcnt <= bcnt + 3'd1;
            end
          end
          S_CHK: begin
            state   <= S_IDLE;
            xor_acc <= '0;
            // Checksum failure wins over channel checks; a foreign GA is
            // dropped quietly once the checksum is good.
            if (I_rx_data != xor_acc) begin
              O_ERR_CHK <= 1'b1;
            end else if (ga_hit) begin
              if (ch_r == CH_BCAST || ch_r < N_CH_B) begin
                for (int k = 0; k < N_CH; k++) begin
                  if (ch_r == CH_BCAST || ch_r == 8'(k)) begin
                    O_WEA[k]                          <= 1'b1;
                    O_WRITE_ADDR[k*ADDR_W +: ADDR_W]  <= addr_sr;
                    O_WRITE_DATA[k*DATA_W +: DATA_W]  <= data_sr;
                  end
                end
                O_FRAME_CNT <= O_FRAME_CNT + 16'd1;
              end else begin
                O_ERR_CH <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        // Stalled inside a frame: abandon it once the idle budget runs out.
        if (to_cnt == TO_LAST) begin
          O_ERR_TO <= 1'b1;
          state    <= S_IDLE;
          to_cnt   <= '0;
          xor_acc  <= '0;
          bcnt     <= '0;
        end else begin
          to_cnt <= to_cnt + TO_ONE;
        end
      end else begin
        xor_acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_ram_writer.sv
// Directed bench for uart_frame_ram_writer: default build plus an
// 8-channel, 16-bit address, 32-bit data build.
`timescale 1ns/1ps
module tb_uart_frame_ram_writer;

  localparam int T = 20000;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_vld;
  logic [4:0]   ga;
  logic [3:0]   wea;
  logic [43:0]  waddr;
  logic [95:0]  wdata;
  logic         err_chk, err_ch, err_to;
  logic [15:0]  fcnt;

  logic [7:0]   rx_data8;
  logic         rx_vld8;
  logic [4:0]   ga8;
  logic [7:0]   wea8;
  logic [127:0] waddr8;
  logic [255:0] wdata8;
  logic         err_chk8, err_ch8, err_to8;
  logic [15:0]  fcnt8;

  int n_vec  = 0;
  int n_miss = 0;

  always #50 clk = ~clk;

  uart_frame_ram_writer #(
    .N_CH(4), .ADDR_W(11), .DATA_W(24), .GA_W(5), .HDR(8'hAA), .TIMEOUT_CYC(T)
  ) dut (
    .I_clk_10M(clk), .I_rst(rst), .I_rx_data(rx_data), .I_rx_vld(rx_vld),
    .I_GA(ga), .O_WEA(wea), .O_WRITE_ADDR(waddr), .O_WRITE_DATA(wdata),
    .O_ERR_CHK(err_chk), .O_ERR_CH(err_ch), .O_ERR_TO(err_to),
    .O_FRAME_CNT(fcnt)
  );

  uart_frame_ram_writer #(
    .N_CH(8), .ADDR_W(16), .DATA_W(32), .GA_W(5), .HDR(8'hAA), .TIMEOUT_CYC(T)
  ) dut8 (
    .I_clk_10M(clk), .I_rst(rst), .I_rx_data(rx_data8), .I_rx_vld(rx_vld8),
    .I_GA(ga8), .O_WEA(wea8), .O_WRITE_ADDR(waddr8), .O_WRITE_DATA(wdata8),
    .O_ERR_CHK(err_chk8), .O_ERR_CH(err_ch8), .O_ERR_TO(err_to8),
    .O_FRAME_CNT(fcnt8)
  );

  task automatic check_vec(input string tag, input logic [127:0] obs,
                           input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns one negedge later, after the byte was taken.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic send9(input logic [71:0] f);
    for (int i = 8; i >= 0; i--) send(f[i*8 +: 8]);
  endtask

  task automatic send8(input logic [7:0] b);
    rx_data8 = b;
    rx_vld8  = 1'b1;
    @(negedge clk);
    rx_vld8  = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_vec({tag, "_errs"}, {125'd0, err_chk, err_ch, err_to}, 128'd0);
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_vld = 1'b0; ga = 5'd3;
    rx_data8 = '0; rx_vld8 = 1'b0; ga8 = 5'd3;
    repeat (3) @(negedge clk);
    check_vec("rst_wea",   128'(wea),   128'd0);
    check_vec("rst_addr",  128'(waddr), 128'd0);
    check_vec("rst_data",  128'(wdata), 128'd0);
    check_vec("rst_cnt",   128'(fcnt),  128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unicast to channel 1, preceded by a junk byte in IDLE.
    send(8'h55);
    send9(72'hAA_03_01_02_34_12_34_56_44);
    check_vec("uni_wea",   128'(wea),   128'h2);
    check_vec("uni_addr",  128'(waddr), 128'(44'h234 << 11));
    check_vec("uni_data",  128'(wdata), 128'(96'h123456 << 24));
    check_vec("uni_cnt",   128'(fcnt),  128'd1);
    check_quiet("uni");
    @(negedge clk);
    check_vec("uni_wea_gone", 128'(wea), 128'd0);

    // Broadcast with GA all ones.
    send9(72'hAA_1F_FF_00_10_00_00_FF_0F);
    check_vec("bc_wea",  128'(wea),   128'hF);
    check_vec("bc_addr", 128'(waddr), 128'({4{11'h010}}));
    check_vec("bc_data", 128'(wdata), 128'({4{24'h0000FF}}));
    check_vec("bc_cnt",  128'(fcnt),  128'd2);

    // Checksum error.
    send9(72'hAA_03_01_02_34_12_34_56_45);
    check_vec("chk_err", 128'(err_chk), 128'd1);
    check_vec("chk_wea", 128'(wea),     128'd0);
    check_vec("chk_ech", 128'(err_ch),  128'd0);
    check_vec("chk_cnt", 128'(fcnt),    128'd2);
    check_vec("chk_addr", 128'(waddr),  128'({4{11'h010}}));
    @(negedge clk);
    check_vec("chk_err_gone", 128'(err_chk), 128'd0);

    // Illegal channel 4.
    send9(72'hAA_03_04_02_34_12_34_56_41);
    check_vec("ich_err", 128'(err_ch),  128'd1);
    check_vec("ich_chk", 128'(err_chk), 128'd0);
    check_vec("ich_wea", 128'(wea),     128'd0);
    check_vec("ich_cnt", 128'(fcnt),    128'd2);

    // Foreign GA, payload full of header bytes: dropped silently.
    send9(72'hAA_02_01_02_34_AA_AA_AA_9F);
    check_vec("ga_wea", 128'(wea), 128'd0);
    check_quiet("ga");
    check_vec("ga_cnt", 128'(fcnt), 128'd2);

    // Next valid frame to channel 2.
    send9(72'hAA_03_02_00_05_00_00_07_03);
    check_vec("nxt_wea",  128'(wea), 128'h4);
    check_vec("nxt_addr", 128'(waddr[22 +: 11]), 128'h005);
    check_vec("nxt_data", 128'(wdata[48 +: 24]), 128'h000007);
    check_vec("nxt_cnt",  128'(fcnt), 128'd3);

    // Timeout after a partial frame.
    send(8'hAA); send(8'h03); send(8'h01);
    repeat (T - 1) @(negedge clk);
    check_vec("to_early", 128'(err_to), 128'd0);
    @(negedge clk);
    check_vec("to_pulse", 128'(err_to), 128'd1);
    @(negedge clk);
    check_vec("to_gone",  128'(err_to), 128'd0);
    send9(72'hAA_03_03_01_23_AB_CD_EF_AB);
    check_vec("to_wea",  128'(wea), 128'h8);
    check_vec("to_addr", 128'(waddr[33 +: 11]), 128'h123);
    check_vec("to_data", 128'(wdata[72 +: 24]), 128'hABCDEF);
    check_vec("to_cnt",  128'(fcnt), 128'd4);

    // Byte lands in the expiry cycle: consumed, no timeout.
    send(8'hAA); send(8'h03); send(8'h01);
    repeat (T - 1) @(negedge clk);
    send(8'h02);
    check_vec("exp_no_to", 128'(err_to), 128'd0);
    send(8'h34); send(8'h12); send(8'h34); send(8'h56); send(8'h44);
    check_vec("exp_wea", 128'(wea), 128'h2);
    check_vec("exp_cnt", 128'(fcnt), 128'd5);
    check_quiet("exp");

    // Reset mid-frame after five bytes.
    send(8'hAA); send(8'h03); send(8'h01); send(8'h02); send(8'h34);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_vec("mrst_wea",  128'(wea),   128'd0);
    check_vec("mrst_addr", 128'(waddr), 128'd0);
    check_vec("mrst_data", 128'(wdata), 128'd0);
    check_vec("mrst_cnt",  128'(fcnt),  128'd0);
    check_quiet("mrst");
    @(negedge clk);
    check_quiet("mrst2");

    // Back-to-back: second header in the first frame's write cycle.
    send9(72'hAA_03_01_02_34_12_34_56_44);
    check_vec("b2b_wea1", 128'(wea), 128'h2);
    send9(72'hAA_03_02_00_05_00_00_07_03);
    check_vec("b2b_wea2", 128'(wea), 128'h4);
    check_vec("b2b_cnt",  128'(fcnt), 128'd2);
    check_vec("b2b_addr", 128'(waddr), 128'({11'h000, 11'h005, 11'h234, 11'h000}));

    // Wide build: channel 7, two address bytes, four data bytes.
    send8(8'hAA); send8(8'h03); send8(8'h07); send8(8'hAB); send8(8'hCD);
    send8(8'h01); send8(8'h02); send8(8'h03); send8(8'h04); send8(8'h66);
    check_vec("w8_wea",  128'(wea8), 128'h80);
    check_vec("w8_addr", waddr8, {16'hABCD, 112'd0});
    check_vec("w8_data", 128'(wdata8[224 +: 32]), 128'h01020304);
    check_vec("w8_low",  wdata8[127:0], 128'd0);
    check_vec("w8_cnt",  128'(fcnt8), 128'd1);
    check_vec("w8_errs", {125'd0, err_chk8, err_ch8, err_to8}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_frame_ram_writer.md
Name: uart_frame_ram_writer

Overview:
- Parses the byte stream from the UART driver (byte plus one-cycle valid) into addressed RAM write frames.
- Issues one-cycle write strobes with address and data to one of N_CH delay RAMs, or to all of them (broadcast).
- Successor to the fixed 4-channel, 11-bit address, 24-bit data receiver: channel count and widths are parametrised, and it adds broadcast, checksum, inter-byte timeout, and error and frame-count reporting.
- Sits between UART_driver and the per-channel delay RAMs.

Parameters:
- N_CH, 4: number of RAM channels (1..254).
- ADDR_W, 11: RAM address width (1..16). AB = ceil(ADDR_W/8) address bytes.
- DATA_W, 24: RAM data width (1..32). DB = ceil(DATA_W/8) data bytes.
- GA_W, 5: geographic address width (1..8).
- HDR, 8'hAA: frame header byte.
- TIMEOUT_CYC, 20000: maximum idle cycles between bytes inside a frame (2 ms at 10 MHz).

Ports:
- I_clk_10M, in, 1: system clock.
- I_rst, in, 1: synchronous, active-high reset.
- I_rx_data, in, 8: received byte.
- I_rx_vld, in, 1: one-cycle strobe; I_rx_data is valid in that cycle.
- I_GA, in, GA_W: board geographic address.
- O_WEA, out, N_CH: per-channel write enable, one-cycle pulse.
- O_WRITE_ADDR, out, N_CH*ADDR_W: channel k address in bits [k*ADDR_W +: ADDR_W].
- O_WRITE_DATA, out, N_CH*DATA_W: channel k data in bits [k*DATA_W +: DATA_W].
- O_ERR_CHK, out, 1: checksum-error pulse.
- O_ERR_CH, out, 1: illegal-channel pulse.
- O_ERR_TO, out, 1: timeout pulse.
- O_FRAME_CNT, out, 16: count of successful writes; wraps at 0xFFFF -> 0.

Behaviour:
- Reset: all outputs 0; parser state IDLE; shift registers, byte counter and timeout counter cleared. Reset mid-frame discards the partial frame with no error pulse.
- Frame format: HDR, GAB, CHB, AB address bytes (MSB first), DB data bytes (MSB first), CHK.
  - CHK = XOR of every byte from GAB through the last data byte.
- Address and data assembly: bytes shift in MSB first. Only the low ADDR_W / DATA_W bits are kept; surplus high bits of the first byte are ignored.
- Bytes are consumed only in cycles where I_rx_vld = 1.
- States: IDLE -> GA -> CH -> ADDR -> DATA -> CHK -> IDLE.
  - IDLE: a byte equal to HDR -> GA; any other byte is dropped.
  - GA: latch ga_hit = (GAB[GA_W-1:0] == I_GA) or (GAB[GA_W-1:0] all ones). Upper GAB bits are ignored.
  - CH: latch CHB.
  - ADDR: stay for AB bytes (byte counter).
  - DATA: stay for DB bytes.
  - CHK: compare the received byte with the running XOR, then return to IDLE.
- Running XOR: cleared in IDLE and accumulated over GAB through the last data byte.
- Outcome of the CHK byte, applied in the cycle after it:
  - Mismatch: O_ERR_CHK = 1 for one cycle. No write, count unchanged.
  - Match, ga_hit = 0: silently dropped, no error.
  - Match, ga_hit = 1, CHB < N_CH: O_WEA[CHB] = 1 for one cycle. Address/data slice CHB updated in the same cycle. O_FRAME_CNT += 1.
  - Match, ga_hit = 1, CHB = 8'hFF: all O_WEA bits = 1 and all slices updated. O_FRAME_CNT += 1 (once).
  - Match, ga_hit = 1, any other CHB: O_ERR_CH = 1 for one cycle. No write, count unchanged.
- Priority: a checksum error outranks an illegal channel; only one error pulse per frame.
- Latency: write and error pulses appear exactly 1 cycle after the CHK byte's valid.
- Hold: address/data slices keep their last written value until that channel's next write; they are never cleared except by reset.
- Back-to-back: the parser is in IDLE in the pulse cycle, so a byte with valid in that cycle is evaluated as a header candidate.
- Timeout:
  - Counter clears on every I_rx_vld and increments each cycle while not IDLE.
  - On reaching TIMEOUT_CYC: O_ERR_TO = 1 for one cycle, state -> IDLE, partial frame discarded.
  - A valid byte in the same cycle as expiry wins: the byte is consumed and there is no timeout.
- A GA mismatch does not resynchronise: the remaining frame bytes are consumed, so HDR values inside payload bytes are never taken as headers.

Test Plan:
- Unicast, defaults, I_GA = 3: bytes AA 03 01 02 34 12 34 56 44 -> O_WEA = 4'b0010 for one cycle, 1 cycle after the 44 byte. O_WRITE_ADDR[21:11] = 11'h234 (0x0234 truncated). O_WRITE_DATA[47:24] = 24'h123456. O_FRAME_CNT = 1. Other channel slices stay 0.
- Broadcast: AA 1F FF 00 10 00 00 FF 0F -> O_WEA = 4'b1111 for one cycle. Every address slice = 11'h010; every data slice = 24'h0000FF. O_FRAME_CNT incremented by exactly 1.
- Checksum error: the unicast frame with last byte 45 -> O_ERR_CHK one-cycle pulse. O_WEA stays 0; outputs and count unchanged.
- Illegal channel and GA filter: CHB = 04 with a valid CHK -> O_ERR_CH pulse, no write. GAB = 02 with I_GA = 3 and a valid CHK -> no write, no error. Next valid frame is accepted normally.
- Timeout and resync: send AA 03 01, then stall TIMEOUT_CYC cycles -> O_ERR_TO pulse at exactly TIMEOUT_CYC. Then a full valid frame -> written. Repeat with a byte arriving in the expiry cycle -> no timeout.
- Reset and back-to-back: assert I_rst after the 5th byte -> all outputs 0 next cycle, no error pulse. Then two valid frames with the second HDR in the first frame's O_WEA cycle -> both written, O_FRAME_CNT = 2. Parametrised rerun N_CH = 8, ADDR_W = 16, DATA_W = 32 with CHB = 7 -> O_WEA[7], 2 address bytes, 4 data bytes, slice 7 updated.
